// File: rtl/parallel_fetch_unit_if.sv
// Bundle and RAM-read bus between the fetch unit (master) and the RAM and decode stage (slave).
interface parallel_fetch_unit_if #(
  parameter int NUM_PORTS = 4
);
  logic [16*NUM_PORTS-1:0] mem_addr;
  logic [16*NUM_PORTS-1:0] mem_rdata;
  logic [16*NUM_PORTS-1:0] bundle_data;
  logic [15:0]             bundle_base;
  logic [NUM_PORTS-1:0]    bundle_mask;
  logic                    bundle_valid;
  logic                    bundle_ready;

  modport master (
    output mem_addr,
    input  mem_rdata,
    output bundle_data,
    output bundle_base,
    output bundle_mask,
    output bundle_valid,
    input  bundle_ready
  );

  modport slave (
    input  mem_addr,
    output mem_rdata,
    input  bundle_data,
    input  bundle_base,
    input  bundle_mask,
    input  bundle_valid,
    output bundle_ready
  );
endinterface

// File: rtl/parallel_fetch_unit.sv
// Parallel fetch unit: reads NUM_PORTS consecutive words per cycle, packs them
// into bundles for the decode stage, and stops at the first halt word.
module parallel_fetch_unit #(
  parameter int          NUM_PORTS  = 4,
  parameter logic [15:0] START_ADDR = 16'h0000,
  parameter logic [15:0] HALT_WORD  = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   start,
  parallel_fetch_unit_if.master  bus,
  output logic                   busy,
  output logic                   halted,
  output logic [15:0]            halt_addr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [15:0]             r_pc;
  logic [16*NUM_PORTS-1:0] r_bundle_data;
  logic [15:0]             r_bundle_base;
  logic [NUM_PORTS-1:0]    r_bundle_mask;
  logic                    r_bundle_valid;
  logic [15:0]             r_halt_addr;

  logic                    w_slot_free;
  logic [NUM_PORTS-1:0]    w_hit;
  logic [NUM_PORTS-1:0]    w_mask;
  logic                    w_hit_any;
  logic [15:0]             w_first_hit;
  logic                    w_fetch_go;

  // Consecutive addresses from pc; 16-bit arithmetic gives the wrap for free.
  // Per-word halt compare and the "no halt at or below this word" mask.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign bus.mem_addr[16*gi +: 16] = r_pc + 16'(gi);
      assign w_hit[gi]  = (bus.mem_rdata[16*gi +: 16] == HALT_WORD);
      assign w_mask[gi] = ~|w_hit[gi:0];
    end
  endgenerate

  assign w_slot_free = !r_bundle_valid || bus.bundle_ready;
  assign w_hit_any   = |w_hit;
  assign w_fetch_go  = (r_state == ST_FETCH) && w_slot_free;

  // Index of the lowest word holding the halt word (NUM_PORTS when none).
  always_comb begin
    w_first_hit = 16'(NUM_PORTS);
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (w_hit[k]) w_first_hit = 16'(k);
    end
  end

  // State register; clear wins over everything.
  always_ff @(posedge clk) begin
    if (clear) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_next = ST_FETCH;
      ST_FETCH:  if (w_slot_free && w_hit_any) w_state_next = ST_HALTED;
      ST_HALTED: w_state_next = ST_HALTED;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy   = (r_state == ST_FETCH);
    halted = (r_state == ST_HALTED);
  end

  // Datapath: pc, bundle register and halt address.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_pc           <= 16'h0000;
      r_bundle_data  <= '0;
      r_bundle_base  <= 16'h0000;
      r_bundle_mask  <= '0;
      r_bundle_valid <= 1'b0;
      r_halt_addr    <= 16'h0000;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_pc <= START_ADDR;
      end
      if (w_fetch_go) begin
        // Word 0 clear of the halt word means at least one instruction to hand over.
        if (w_mask[0]) begin
          r_bundle_data  <= bus.mem_rdata;
          r_bundle_base  <= r_pc;
          r_bundle_mask  <= w_mask;
          r_bundle_valid <= 1'b1;
        end else begin
          r_bundle_valid <= 1'b0;
        end
        if (w_hit_any) r_halt_addr <= r_pc + w_first_hit;
        else           r_pc        <= r_pc + 16'(NUM_PORTS);
      end
      if (r_state == ST_HALTED && r_bundle_valid && bus.bundle_ready) begin
        r_bundle_valid <= 1'b0;
      end
    end
  end

  assign bus.bundle_data  = r_bundle_data;
  assign bus.bundle_base  = r_bundle_base;
  assign bus.bundle_mask  = r_bundle_mask;
  assign bus.bundle_valid = r_bundle_valid;
  assign halt_addr        = r_halt_addr;

endmodule

// File: tb/tb_parallel_fetch_unit.sv
// Directed bench for parallel_fetch_unit: one DUT at START_ADDR 0, one at FFFE for wrap.
module tb_parallel_fetch_unit;

  logic clk;
  logic clear;
  logic start0, start1;
  logic busy0, busy1, halted0, halted1;
  logic [15:0] halt_addr0, halt_addr1;

  logic [15:0] mem [0:65535];

  int n_cmp = 0;
  int n_err = 0;

  parallel_fetch_unit_if #(.NUM_PORTS(4)) bus0 ();
  parallel_fetch_unit_if #(.NUM_PORTS(4)) bus1 ();

  parallel_fetch_unit #(.NUM_PORTS(4), .START_ADDR(16'h0000), .HALT_WORD(16'hFFFF)) dut0 (
    .clk(clk), .clear(clear), .start(start0), .bus(bus0.master),
    .busy(busy0), .halted(halted0), .halt_addr(halt_addr0)
  );

  parallel_fetch_unit #(.NUM_PORTS(4), .START_ADDR(16'hFFFE), .HALT_WORD(16'hFFFF)) dut1 (
    .clk(clk), .clear(clear), .start(start1), .bus(bus1.master),
    .busy(busy1), .halted(halted1), .halt_addr(halt_addr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational RAM shared by both DUTs.
  always_comb begin
    bus0.mem_rdata = '0;
    bus1.mem_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      bus0.mem_rdata[16*k +: 16] = mem[bus0.mem_addr[16*k +: 16]];
      bus1.mem_rdata[16*k +: 16] = mem[bus1.mem_addr[16*k +: 16]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    clear = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    bus0.bundle_ready = 1'b1;
    bus1.bundle_ready = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) & 16'h7FFF;
    #2;

    // ---- Reset state ----
    do_clear();
    check("rst_valid", bus0.bundle_valid, 0);
    check("rst_data", bus0.bundle_data, 0);
    check("rst_base", bus0.bundle_base, 0);
    check("rst_mask", bus0.bundle_mask, 0);
    check("rst_busy", busy0, 0);
    check("rst_halted", halted0, 0);
    check("rst_haddr", halt_addr0, 0);
    check("rst_addr", bus0.mem_addr, 64'h0003_0002_0001_0000);

    // ---- Run to halt on a bundle boundary ----
    $display("T1 halt on bundle boundary");
    mem[8] = 16'hFFFF;
    start0 = 1'b1;
    tick();                                   // E0
    start0 = 1'b0;
    check("t1_e0_busy", busy0, 1);
    check("t1_e0_valid", bus0.bundle_valid, 0);
    check("t1_e0_addr", bus0.mem_addr, 64'h0003_0002_0001_0000);
    tick();                                   // E1
    check("t1_b0_valid", bus0.bundle_valid, 1);
    check("t1_b0_base", bus0.bundle_base, 16'h0000);
    check("t1_b0_data", bus0.bundle_data, 64'h0003_0002_0001_0000);
    check("t1_b0_mask", bus0.bundle_mask, 4'b1111);
    tick();                                   // E2
    check("t1_b1_valid", bus0.bundle_valid, 1);
    check("t1_b1_base", bus0.bundle_base, 16'h0004);
    check("t1_b1_data", bus0.bundle_data, 64'h0007_0006_0005_0004);
    check("t1_b1_mask", bus0.bundle_mask, 4'b1111);
    tick();                                   // halt word in slot 0
    check("t1_h_valid", bus0.bundle_valid, 0);
    check("t1_h_halted", halted0, 1);
    check("t1_h_busy", busy0, 0);
    check("t1_h_haddr", halt_addr0, 16'h0008);
    tick();
    check("t1_no_third", bus0.bundle_valid, 0);
    mem[8] = 16'h0008;

    // ---- Halt in mid-bundle, drain, start ignored ----
    $display("T2 halt mid-bundle");
    do_clear();
    mem[6] = 16'hFFFF;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    check("t2_b0_base", bus0.bundle_base, 16'h0000);
    tick();
    check("t2_b1_base", bus0.bundle_base, 16'h0004);
    check("t2_b1_mask", bus0.bundle_mask, 4'b0011);
    check("t2_b1_data", bus0.bundle_data, 64'h0007_FFFF_0005_0004);
    check("t2_b1_valid", bus0.bundle_valid, 1);
    check("t2_haddr", halt_addr0, 16'h0006);
    check("t2_halted", halted0, 1);
    bus0.bundle_ready = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("t2_hold_valid", bus0.bundle_valid, 1);
    check("t2_hold_halted", halted0, 1);
    bus0.bundle_ready = 1'b1;
    tick();
    check("t2_drain_valid", bus0.bundle_valid, 0);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("t2_start_ign_busy", busy0, 0);
    check("t2_start_ign_halted", halted0, 1);
    check("t2_start_ign_valid", bus0.bundle_valid, 0);
    mem[6] = 16'h0006;

    // ---- Backpressure ----
    $display("T3 backpressure");
    do_clear();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    check("t3_b0_base", bus0.bundle_base, 16'h0000);
    bus0.bundle_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      $display("T3 stall cycle %0d", c);
      check("t3_stall_valid", bus0.bundle_valid, 1);
      check("t3_stall_base", bus0.bundle_base, 16'h0000);
      check("t3_stall_data", bus0.bundle_data, 64'h0003_0002_0001_0000);
      check("t3_stall_mask", bus0.bundle_mask, 4'b1111);
      check("t3_stall_addr", bus0.mem_addr, 64'h0007_0006_0005_0004);
    end
    bus0.bundle_ready = 1'b1;
    tick();
    check("t3_resume_base", bus0.bundle_base, 16'h0004);
    check("t3_resume_data", bus0.bundle_data, 64'h0007_0006_0005_0004);
    bus0.bundle_ready = 1'b0;

    // ---- Clear mid-handshake ----
    $display("T5 clear mid-handshake");
    check("t5_pre_valid", bus0.bundle_valid, 1);
    do_clear();
    check("t5_valid", bus0.bundle_valid, 0);
    check("t5_data", bus0.bundle_data, 0);
    check("t5_base", bus0.bundle_base, 0);
    check("t5_mask", bus0.bundle_mask, 0);
    check("t5_busy", busy0, 0);
    check("t5_halted", halted0, 0);
    check("t5_addr", bus0.mem_addr, 64'h0003_0002_0001_0000);
    tick();
    check("t5_idle_busy", busy0, 0);
    bus0.bundle_ready = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("t5_restart_busy", busy0, 1);
    check("t5_restart_addr", bus0.mem_addr, 64'h0003_0002_0001_0000);
    tick();
    check("t5_restart_base", bus0.bundle_base, 16'h0000);
    check("t5_restart_valid", bus0.bundle_valid, 1);

    // ---- Immediate halt ----
    $display("T6 immediate halt");
    do_clear();
    mem[0] = 16'hFFFF;
    start0 = 1'b1;
    tick();                                   // E0
    start0 = 1'b0;
    check("t6_e0_halted", halted0, 0);
    check("t6_e0_busy", busy0, 1);
    tick();                                   // E1
    check("t6_halted", halted0, 1);
    check("t6_valid", bus0.bundle_valid, 0);
    check("t6_haddr", halt_addr0, 16'h0000);
    check("t6_busy", busy0, 0);
    tick();
    check("t6_valid_later", bus0.bundle_valid, 0);

    // ---- Address wrap on the FFFE instance ----
    $display("T4 address wrap");
    mem[16'hFFFE] = 16'h000A;
    mem[16'hFFFF] = 16'h000B;
    mem[0]        = 16'h000C;
    mem[1]        = 16'h000D;
    do_clear();
    check("t4_rst_addr", bus1.mem_addr, 64'h0003_0002_0001_0000);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("t4_addr", bus1.mem_addr, 64'h0001_0000_FFFF_FFFE);
    tick();
    check("t4_b0_base", bus1.bundle_base, 16'hFFFE);
    check("t4_b0_data", bus1.bundle_data, 64'h000D_000C_000B_000A);
    check("t4_b0_mask", bus1.bundle_mask, 4'b1111);
    tick();
    check("t4_b1_base", bus1.bundle_base, 16'h0002);
    check("t4_b1_data", bus1.bundle_data, 64'h0005_0004_0003_0002);
    check("t4_halted", halted1, 0);
    check("t4_busy", busy1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
